// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and its control unit:
// FSM state encodings, opcode constants, write-back source codes and the decode bundle.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_RELU   = 4'h5;
  localparam logic [3:0] OP_SIGM   = 4'h6;
  localparam logic [3:0] OP_SIGD   = 4'h7;
  localparam logic [3:0] OP_SETCNT = 4'hD;
  localparam logic [3:0] OP_DJNZ   = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] DST_ALU     = 2'd0;
  localparam logic [1:0] DST_SIGMOID = 2'd1;
  localparam logic [1:0] DST_RELU    = 2'd2;
  localparam logic [1:0] DST_SIGDIFF = 2'd3;

  typedef struct packed {
    logic       alu;
    logic       setcnt;
    logic       djnz;
    logic       halt;
    logic       illegal;
    logic [1:0] op_sel;
    logic [1:0] dest;
  } dec_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction memory bus: sequencer drives the address, memory returns data one cycle later.
interface program_sequencer_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_in;

  modport master (output pc, input instr_in);
  modport slave  (input pc, output instr_in);
endinterface

// File: rtl/program_sequencer_decode.sv
// Opcode-to-control decode; purely combinational.
module seq_decode
  import program_sequencer_pkg::*;
(
  input  logic [3:0] i_opcode,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        o_dec.alu    = 1'b1;
        o_dec.op_sel = i_opcode[1:0] - 2'd1;
        o_dec.dest   = DST_ALU;
      end
      OP_RELU: begin o_dec.alu = 1'b1; o_dec.dest = DST_RELU;    end
      OP_SIGM: begin o_dec.alu = 1'b1; o_dec.dest = DST_SIGMOID; end
      OP_SIGD: begin o_dec.alu = 1'b1; o_dec.dest = DST_SIGDIFF; end
      OP_SETCNT: o_dec.setcnt = 1'b1;
      OP_DJNZ:   o_dec.djnz   = 1'b1;
      OP_HALT:   o_dec.halt   = 1'b1;
      OP_NOP:    o_dec        = '0;
      default:   o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches 16-bit instructions, sequences datapath strobes,
// and handles a counted loop (SETCNT/DJNZ) and HALT.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  program_sequencer_if.master imem,
  output logic [15:0]         instruction,
  output logic                enable_ALU,
  output logic                enable_sel_mem,
  output logic                write_enable_mem,
  output logic [1:0]          op_select,
  output logic [1:0]          dest_control,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic [7:0]        r_cnt;
  logic              r_alu, r_setcnt, r_djnz;
  logic [1:0]        r_op_sel, r_dest;
  logic              r_en_alu, r_en_sel, r_we, r_done, r_illegal;
  dec_t              w_dec;

  seq_decode u_dec (
    .i_opcode (imem.instr_in[15:12]),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_cnt     <= '0;
      r_alu     <= 1'b0;
      r_setcnt  <= 1'b0;
      r_djnz    <= 1'b0;
      r_op_sel  <= '0;
      r_dest    <= '0;
      r_en_alu  <= 1'b0;
      r_en_sel  <= 1'b0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!stall) begin
      // Strobes are single-cycle unless a stall freezes them in place.
      r_en_alu <= 1'b0;
      r_en_sel <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_pc      <= '0;
          r_illegal <= 1'b0;
          r_state   <= FETCH;
        end
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_instr  <= imem.instr_in;
          r_alu    <= w_dec.alu;
          r_setcnt <= w_dec.setcnt;
          r_djnz   <= w_dec.djnz;
          r_op_sel <= w_dec.op_sel;
          r_dest   <= w_dec.dest;
          if (w_dec.halt) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= EXEC;
            r_en_alu <= w_dec.alu;
            r_en_sel <= w_dec.alu;
            if (w_dec.illegal) r_illegal <= 1'b1;
          end
        end
        EXEC: if (r_alu) begin
          r_state <= WRITE;
          r_we    <= 1'b1;
        end else begin
          r_state <= FETCH;
          r_pc    <= r_pc + 1'b1;
          if (r_setcnt) r_cnt <= r_instr[7:0];
          else if (r_djnz) begin
            // Counter saturates at zero; only a count above one takes the branch.
            if (r_cnt > 8'd1) begin
              r_cnt <= r_cnt - 8'd1;
              r_pc  <= r_instr[ADDR_W-1:0];
            end else begin
              r_cnt <= 8'd0;
            end
          end
        end
        WRITE: begin
          r_state <= FETCH;
          r_pc    <= r_pc + 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem.pc          = r_pc;
  assign instruction      = r_instr;
  assign enable_ALU       = r_en_alu;
  assign enable_sel_mem   = r_en_sel;
  assign write_enable_mem = r_we;
  assign op_select        = r_op_sel;
  assign dest_control     = r_dest;
  assign busy             = (r_state != IDLE);
  assign done             = r_done;
  assign illegal          = r_illegal;

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to run the program from address 0.
REQ-005 SHALL have port stall  input  1  while high, FSM state, pc, loop counter and all enables hold.
REQ-006 SHALL have port instr_in  input  16  instruction memory read data, valid one cycle after pc is presented.
REQ-007 SHALL have port pc  output  ADDR_W  instruction memory address.
REQ-008 SHALL have port instruction  output  16  latched current instruction: opcode[15:12], read field 1 [11:8], read field 2 [7:4], write field [3:0].
REQ-009 SHALL have ports enable_ALU, enable_sel_mem, write_enable_mem  output  1 each  datapath strobes.
REQ-010 SHALL have ports op_select, dest_control  output  2 each  ALU operation and write-back source (0 ALU, 1 sigmoid, 2 ReLu, 3 sigmoid_diff).
REQ-011 SHALL have ports busy, done, illegal  output  1 each  running flag, one-cycle completion pulse, sticky reserved-opcode flag.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WRITE, DONE.
REQ-013 IDLE: start=1 SHALL set pc=0, clear illegal and go to FETCH; start is ignored in any other state.
REQ-014 FETCH SHALL present pc and go to DECODE; DECODE SHALL latch instr_in into instruction and go to EXEC, or to DONE on opcode 0xF.
REQ-015 Opcodes 0x1-0x4 SHALL drive op_select=opcode-1, dest_control=0; 0x5 ReLu, 0x6 sigmoid, 0x7 sigmoid_diff SHALL drive op_select=0 with dest_control 2, 1, 3.
REQ-016 For opcodes 0x1-0x7, EXEC SHALL assert enable_ALU and enable_sel_mem for exactly one cycle; WRITE SHALL assert write_enable_mem for exactly one cycle; then pc increments and FSM returns to FETCH (4 cycles per instruction).
REQ-017 Opcode 0xD (SETCNT) SHALL load an 8-bit loop counter with instruction[7:0] in EXEC, then pc+1, FETCH (3 cycles).
REQ-018 Opcode 0xE (DJNZ) in EXEC: if loop counter >1, SHALL decrement it and set pc=instruction[ADDR_W-1:0]; if counter is 1, SHALL decrement to 0 and set pc+1; if 0, SHALL leave it at 0 and set pc+1.
REQ-019 Opcode 0x0 SHALL be NOP (3 cycles, no strobes); opcodes 0x8-0xC SHALL behave as NOP and set illegal=1 until next start or reset.
REQ-020 DONE SHALL assert done for one cycle, then go to IDLE; pc holds the HALT address.
REQ-021 pc increment from 2^ADDR_W-1 SHALL wrap to 0 without halting.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 op_select and dest_control SHALL be stable from DECODE exit through WRITE.
REQ-024 stall=1 SHALL freeze state; strobes asserted on entry to a stalled state remain asserted for the stall duration; done is not re-pulsed.
REQ-025 stall and start together in IDLE: stall SHALL win; start must be re-issued.

Reset
REQ-026 reset=1 at a clock edge SHALL, in any state including mid-instruction, force IDLE, pc=0, instruction=0, loop counter=0, all strobes, op_select, dest_control, busy, done, illegal =0.
REQ-027 reset SHALL take priority over start and stall.

Structure
REQ-028 Opcode constants, FSM state encodings and dest_control codes SHALL reside in a shared package/include used by CU and this block.
REQ-029 Opcode-to-control decode SHALL be one combinational sub-module, seq_decode.

Verification
REQ-030 Program {0x1123, 0xF000}, start -> enable_ALU at cycle 3, write_enable_mem at cycle 4, op_select=0, done at cycle 7, busy low cycle 8.
REQ-031 Program {0xD003, 0x2456, 0xE001, 0xF000} -> opcode 0x2 executes 3 times, 3 write_enable_mem pulses, loop counter ends 0, done once.
REQ-032 Opcode 0x6 -> dest_control=1, op_select=0 during EXEC/WRITE; opcode 0xA -> no strobes, illegal=1 at done.
REQ-033 Assert reset during WRITE -> next cycle write_enable_mem=0, pc=0, busy=0; start afterwards reruns from address 0.
REQ-034 stall high 5 cycles during EXEC -> enable_ALU high 5+1 cycles, pc unchanged; start pulsed while busy -> ignored.
REQ-035 ADDR_W=4, 16 NOPs with no HALT -> pc wraps 15->0, busy stays 1.
